// File: rtl/gpu_instr_fifo.sv
// First-word-fall-through instruction FIFO between the Nios II PIO exports and the GPU.
// Optional build macro GPU_FIFO_DROP_CNT_EN enables the saturating drop_count counter.
module gpu_instr_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [DATA_W-1:0]          data_a_in,
    input  logic [DATA_W-1:0]          data_b_in,
    input  logic                       wrreg_in,
    output logic                       wrfull_out,
    output logic [DATA_W-1:0]          instr_a_out,
    output logic [DATA_W-1:0]          instr_b_out,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     fill_count,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam int LANES = 2;

    logic                 wrreg_d_reg;
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     fill_reg;
    logic                 overflow_reg;

    logic                 push_req;
    logic                 pop;
    logic                 full;
    logic                 push;
    logic                 drop;
    logic [PTR_W-1:0]     wr_ptr_next;
    logic [PTR_W-1:0]     rd_ptr_next;
    logic [CNT_W-1:0]     fill_next;

    logic [DATA_W-1:0]    lane_in  [LANES];
    logic [DATA_W-1:0]    lane_out [LANES];

    assign lane_in[0] = data_a_in;
    assign lane_in[1] = data_b_in;

    always_comb begin
        push_req    = wrreg_in & ~wrreg_d_reg;
        full        = (fill_reg == FULL_CNT);
        pop         = (fill_reg != '0) & instr_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push        = push_req & (~full | pop);
        drop        = push_req & full & ~pop;
        wr_ptr_next = push ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
        fill_next   = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + CNT_W'(1);
            2'b01:   fill_next = fill_reg - CNT_W'(1);
            default: fill_next = fill_reg;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            // Held at 1 so a strobe still high when reset releases is not a rise.
            wrreg_d_reg  <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wrreg_d_reg  <= wrreg_in;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            fill_reg     <= fill_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Each word lane owns its storage plus a registered head; the head is read at
    // the next read pointer, bypassing the incoming word when it becomes the head.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [DEPTH];
            logic [DATA_W-1:0] head_reg;

            always_ff @(posedge clk_clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= lane_in[gi];
                end
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    head_reg <= '0;
                end else if (fill_next == '0) begin
                    head_reg <= '0;
                end else if (push && (wr_ptr_reg == rd_ptr_next)) begin
                    head_reg <= lane_in[gi];
                end else begin
                    head_reg <= mem[rd_ptr_next];
                end
            end

            assign lane_out[gi] = head_reg;
        end
    endgenerate

`ifdef GPU_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            drop_cnt_reg <= '0;
        end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_count = drop_cnt_reg;
`else
    assign drop_count = '0;
`endif

    assign instr_a_out = lane_out[0];
    assign instr_b_out = lane_out[1];
    assign instr_valid = (fill_reg != '0);
    assign wrfull_out  = full;
    assign fill_count  = fill_reg;
    assign overflow    = overflow_reg;

endmodule

// File: tb/tb_gpu_instr_fifo.sv
// Scoreboard bench for gpu_instr_fifo: directed pushes queue expected words, a monitor checks pops.
module tb_gpu_instr_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [DATA_W-1:0] data_a_in;
    logic [DATA_W-1:0] data_b_in;
    logic              wrreg_in;
    logic              wrfull_out;
    logic [DATA_W-1:0] instr_a_out;
    logic [DATA_W-1:0] instr_b_out;
    logic              instr_valid;
    logic              instr_ready;
    logic [4:0]        fill_count;
    logic              overflow;
    logic [15:0]       drop_count;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [DATA_W-1:0] exp_a_q [$];
    logic [DATA_W-1:0] exp_b_q [$];

`ifdef GPU_FIFO_DROP_CNT_EN
    localparam logic [15:0] DROP_ONE = 16'd1;
`else
    localparam logic [15:0] DROP_ONE = 16'd0;
`endif

    gpu_instr_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .data_a_in   (data_a_in),
        .data_b_in   (data_b_in),
        .wrreg_in    (wrreg_in),
        .wrfull_out  (wrfull_out),
        .instr_a_out (instr_a_out),
        .instr_b_out (instr_b_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fill_count  (fill_count),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Monitor: sample mid-cycle; a valid&ready seen here is the handshake on the next edge.
    always @(negedge clk_clk) begin
        if (!reset_reset && instr_valid && instr_ready) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%h_%h required=none", instr_a_out, instr_b_out);
            end else begin
                logic [DATA_W-1:0] ea, eb;
                ea = exp_a_q.pop_front();
                eb = exp_b_q.pop_front();
                $display("POP %0d a=%h b=%h", pops, instr_a_out, instr_b_out);
                pops++;
                chk("pop_a", instr_a_out, ea);
                chk("pop_b", instr_b_out, eb);
            end
        end
    end

    // One push transaction: rise for one cycle, low for one cycle.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input bit accept);
        data_a_in = a;
        data_b_in = b;
        wrreg_in  = 1'b1;
        if (accept) begin
            exp_a_q.push_back(a);
            exp_b_q.push_back(b);
        end
        $display("PUSH a=%h b=%h accept=%0d", a, b, accept);
        tick();
        wrreg_in = 1'b0;
        tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        instr_ready = 1'b1;
        while (instr_valid && n < budget) begin
            tick();
            n++;
        end
        instr_ready = 1'b0;
        chk("drain_done_valid", {31'd0, instr_valid}, 32'd0);
        chk("drain_done_fill", {27'd0, fill_count}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_reset = 1'b1;
        wrreg_in    = 1'b1;
        instr_ready = 1'b0;
        data_a_in   = '0;
        data_b_in   = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_fill", {27'd0, fill_count}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_a", instr_a_out, 32'd0);
        chk("rst_b", instr_b_out, 32'd0);
        chk("rst_full", {31'd0, wrfull_out}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_drop", {16'd0, drop_count}, 32'd0);

        // Strobe held high through reset release: no push
        reset_reset = 1'b0;
        repeat (5) tick();
        chk("held_fill", {27'd0, fill_count}, 32'd0);
        chk("held_valid", {31'd0, instr_valid}, 32'd0);
        wrreg_in = 1'b0;
        tick();

        // One 3-cycle strobe -> exactly one push, visible the next cycle
        data_a_in = 32'h0000_0011;
        data_b_in = 32'h00AB_CDEF;
        wrreg_in  = 1'b1;
        exp_a_q.push_back(32'h0000_0011);
        exp_b_q.push_back(32'h00AB_CDEF);
        tick();
        chk("first_valid", {31'd0, instr_valid}, 32'd1);
        chk("first_a", instr_a_out, 32'h0000_0011);
        chk("first_b", instr_b_out, 32'h00AB_CDEF);
        chk("first_fill", {27'd0, fill_count}, 32'd1);
        repeat (2) tick();
        wrreg_in = 1'b0;
        tick();
        chk("one_push_fill", {27'd0, fill_count}, 32'd1);
        drain(4);

        // Fill to DEPTH, then one rejected push, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h0000_0100 + i, 32'hB000_0000 + i, 1'b1);
        end
        chk("full_flag", {31'd0, wrfull_out}, 32'd1);
        chk("full_fill", {27'd0, fill_count}, 32'd16);
        chk("full_no_ovf", {31'd0, overflow}, 32'd0);
        push(32'hDEAD_0017, 32'hDEAD_0017, 1'b0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_fill", {27'd0, fill_count}, 32'd16);
        chk("ovf_drop", {16'd0, drop_count}, {16'd0, DROP_ONE});
        drain(20);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        wrreg_in    = 1'b0;
        tick();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO: push and pop on the same edge
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h0000_0200 + i, 32'hC000_0000 + i, 1'b1);
        end
        chk("full2_fill", {27'd0, fill_count}, 32'd16);
        instr_ready = 1'b1;
        data_a_in   = 32'hAAAA_AAAA;
        data_b_in   = 32'h5555_5555;
        wrreg_in    = 1'b1;
        exp_a_q.push_back(32'hAAAA_AAAA);
        exp_b_q.push_back(32'h5555_5555);
        tick();
        wrreg_in = 1'b0;
        chk("pushpop_fill", {27'd0, fill_count}, 32'd16);
        chk("pushpop_no_ovf", {31'd0, overflow}, 32'd0);
        drain(20);

        // Interleaved pushes with pseudo-random ready: wraps pointers
        for (int i = 0; i < 40; i++) begin
            bit rdy;
            bit acc;
            rdy = ($urandom_range(0, 2) != 0);
            instr_ready = rdy;
            acc = (exp_a_q.size() < DEPTH) || (rdy && exp_a_q.size() > 0);
            data_a_in = 32'h0000_0300 + i;
            data_b_in = 32'hD000_0000 + i;
            wrreg_in  = 1'b1;
            if (acc) begin
                exp_a_q.push_back(data_a_in);
                exp_b_q.push_back(data_b_in);
            end
            tick();
            chk("mix_fill", {27'd0, fill_count}, exp_a_q.size());
            instr_ready = ($urandom_range(0, 1) != 0);
            wrreg_in = 1'b0;
            tick();
            chk("mix_fill2", {27'd0, fill_count}, exp_a_q.size());
        end
        chk("mix_no_ovf", {31'd0, overflow}, 32'd0);
        drain(40);

        // Reset with 7 entries and a push edge on the same cycle
        for (int i = 0; i < 7; i++) begin
            push(32'h0000_0400 + i, 32'hE000_0000 + i, 1'b1);
        end
        chk("seven_fill", {27'd0, fill_count}, 32'd7);
        reset_reset = 1'b1;
        wrreg_in    = 1'b1;
        data_a_in   = 32'hFFFF_0000;
        data_b_in   = 32'h0000_FFFF;
        tick();
        exp_a_q.delete();
        exp_b_q.delete();
        chk("midrst_fill", {27'd0, fill_count}, 32'd0);
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_full", {31'd0, wrfull_out}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);
        chk("midrst_a", instr_a_out, 32'd0);
        reset_reset = 1'b0;
        tick();
        wrreg_in = 1'b0;
        tick();
        chk("postrst_fill", {27'd0, fill_count}, 32'd0);

        chk("scoreboard_empty", exp_a_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
